half_subtractor: RTL and testbench
==================================

HALF_SUBTRACTOR -- requirements
Module: half_subtractor

Interface
REQ-001 Parameter WIDTH, default 1: operand and difference width in bits.
REQ-002 Parameter CNT_WIDTH, default 8: width of the borrow event counter.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port a, input, WIDTH: minuend.
REQ-006 Port b, input, WIDTH: subtrahend.
REQ-007 Port in_valid, input, 1: a/b are qualified this cycle.
REQ-008 Port diff, output, WIDTH: registered a - b, modulo 2^WIDTH.
REQ-009 Port borrow, output, 1: registered borrow-out; 1 when unsigned a < b.
REQ-010 Port out_valid, output, 1: diff/borrow hold a new result this cycle.
REQ-011 Port borrow_count, output, CNT_WIDTH: saturating count of results with borrow=1.

Function
REQ-012 For WIDTH=1, the captured values SHALL be diff = a XOR b and borrow = (NOT a) AND b.
REQ-013 For WIDTH>1, the captured values SHALL be an unsigned ripple subtraction: diff = (a - b) mod 2^WIDTH, and borrow = 1 iff a < b.
REQ-014 Latency SHALL be exactly 1 cycle: a/b sampled at edge N with in_valid=1 appear on diff/borrow after edge N, with out_valid=1 for that one cycle.
REQ-015 A cycle with in_valid=0 SHALL hold diff/borrow at their last values and drive out_valid=0 after the edge.
REQ-016 Back-to-back in_valid=1 cycles SHALL each produce a result; there is no backpressure and no stall.
REQ-017 borrow_count SHALL increment by 1 on each accepted input whose borrow is 1.
REQ-018 borrow_count SHALL saturate at 2^CNT_WIDTH - 1 and SHALL NOT wrap.
REQ-019 Operands of all-zero, equal values, or a=0 with b=max SHALL follow REQ-012/013 with no special-casing (equal operands: diff=0, borrow=0).

Reset
REQ-020 When rst=1 at a rising edge, diff=0, borrow=0, out_valid=0 and borrow_count=0 after that edge.
REQ-021 rst SHALL take priority over in_valid; an input presented in a reset cycle SHALL be discarded.
REQ-022 The first valid input after rst deasserts SHALL be processed normally, with the standard 1-cycle latency.
REQ-023 Outputs SHALL be undefined-free (never X) from the first reset edge onward.

Structure
REQ-024 No shared package is required; WIDTH and CNT_WIDTH are module parameters only.
REQ-025 One combinational sub-module, hs_bit_cell (inputs x, y; outputs d = x^y, bo = ~x&y), SHALL be used.
REQ-026 Each bit stage SHALL be built from two hs_bit_cell instances plus an OR of their borrows, forming a full subtractor.
REQ-027 For WIDTH=1, the datapath SHALL reduce to a single hs_bit_cell.
REQ-028 All outputs SHALL be driven directly from flops.

Verification
REQ-029 WIDTH=1, in_valid=1, (a,b) = 00, 01, 10, 11 on consecutive cycles -> (diff,borrow) = (0,0), (1,1), (1,0), (0,0), each 1 cycle later; borrow_count ends at 1.
REQ-030 Reset test: rst=1 for 2 cycles with in_valid=1, a=0, b=1 -> all outputs 0, borrow_count stays 0; after release, the same input gives diff=1, borrow=1.
REQ-031 Hold test: a=1, b=0 valid, then in_valid=0 for 3 cycles -> diff=1 and borrow=0 held, out_valid=0 during the hold cycles.
REQ-032 Saturation test: CNT_WIDTH=2, 5 inputs with a=0, b=1 -> borrow_count = 1, 2, 3, 3, 3.
REQ-033 WIDTH=4 test: a=3, b=5 -> diff=14, borrow=1; a=9, b=9 -> diff=0, borrow=0; a=15, b=0 -> diff=15, borrow=0.
REQ-034 Reset during streaming: assert rst mid-sequence -> the next edge clears everything, no stale result appears afterwards, and borrow_count restarts from 0.

Source files
------------

// File: rtl/half_subtractor_pkg.sv
// Shared helpers for the half_subtractor datapath.
//   fs_borrow : borrow-out of a full-subtractor stage built from two half cells.
package half_subtractor_pkg;

  // A stage borrows if either the a-b half cell or the (a^b)-bin half cell borrows;
  // the two can never both be 1, so OR is exact.
  function automatic logic fs_borrow(input logic bo_lo, input logic bo_hi);
    return bo_lo | bo_hi;
  endfunction

endpackage

// File: rtl/half_subtractor_bit_cell.sv
// hs_bit_cell: one-bit half subtractor, purely combinational.
// Ports:
//   x  : minuend bit
//   y  : subtrahend bit
//   d  : difference bit, x ^ y
//   bo : borrow-out, ~x & y
module hs_bit_cell (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/half_subtractor.sv
// half_subtractor: registered unsigned subtractor with 1-cycle latency and a
// saturating counter of results that borrowed.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   a, b         : minuend / subtrahend, qualified by in_valid
//   in_valid     : a/b valid this cycle
//   diff         : registered (a - b) mod 2^WIDTH
//   borrow       : registered borrow-out (a < b)
//   out_valid    : diff/borrow carry a new result this cycle
//   borrow_count : saturating count of accepted inputs with borrow=1
module half_subtractor
  import half_subtractor_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_valid,
  output logic [WIDTH-1:0]     diff,
  output logic                 borrow,
  output logic                 out_valid,
  output logic [CNT_WIDTH-1:0] borrow_count
);

  logic [WIDTH-1:0] diff_next;
  logic             borrow_next;

  generate
    if (WIDTH == 1) begin : g_half
      // No borrow-in exists for a single bit, so one half cell is the whole datapath.
      hs_bit_cell u_cell (
        .x  (a[0]),
        .y  (b[0]),
        .d  (diff_next[0]),
        .bo (borrow_next)
      );
    end else begin : g_ripple
      logic [WIDTH:0] chain;
      assign chain[0] = 1'b0;

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic d_lo;
        logic bo_lo;
        logic bo_hi;

        hs_bit_cell u_lo (
          .x  (a[i]),
          .y  (b[i]),
          .d  (d_lo),
          .bo (bo_lo)
        );

        hs_bit_cell u_hi (
          .x  (d_lo),
          .y  (chain[i]),
          .d  (diff_next[i]),
          .bo (bo_hi)
        );

        assign chain[i+1] = fs_borrow(bo_lo, bo_hi);
      end

      assign borrow_next = chain[WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      diff         <= '0;
      borrow       <= 1'b0;
      out_valid    <= 1'b0;
      borrow_count <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff   <= diff_next;
        borrow <= borrow_next;
        // Stick at all-ones instead of wrapping.
        if (borrow_next && (borrow_count != {CNT_WIDTH{1'b1}}))
          borrow_count <= borrow_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_half_subtractor.sv
module tb_half_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  // u1: WIDTH=1, CNT_WIDTH=8
  logic       a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
  logic       d1, bo1, ov1;
  logic [7:0] c1;
  // u2: WIDTH=1, CNT_WIDTH=2 (saturation)
  logic       a2 = 1'b0, b2 = 1'b0, v2 = 1'b0;
  logic       d2, bo2, ov2;
  logic [1:0] c2;
  // u3: WIDTH=4, CNT_WIDTH=8
  logic [3:0] a3 = '0, b3 = '0;
  logic       v3 = 1'b0;
  logic [3:0] d3;
  logic       bo3, ov3;
  logic [7:0] c3;

  half_subtractor #(.WIDTH(1), .CNT_WIDTH(8)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
    .diff(d1), .borrow(bo1), .out_valid(ov1), .borrow_count(c1));

  half_subtractor #(.WIDTH(1), .CNT_WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .in_valid(v2),
    .diff(d2), .borrow(bo2), .out_valid(ov2), .borrow_count(c2));

  half_subtractor #(.WIDTH(4), .CNT_WIDTH(8)) u3 (
    .clk(clk), .rst(rst), .a(a3), .b(b3), .in_valid(v3),
    .diff(d3), .borrow(bo3), .out_valid(ov3), .borrow_count(c3));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vectors for the WIDTH=1 truth table: {a, b, diff, borrow, count}
  logic [4:0] tt_vec [4] = '{5'b00_00_0, 5'b01_11_1, 5'b10_10_1, 5'b11_00_1};
  // WIDTH=4 vectors: a, b, diff, borrow
  logic [3:0] w4_a [4] = '{4'd3, 4'd9, 4'd15, 4'd0};
  logic [3:0] w4_b [4] = '{4'd5, 4'd9, 4'd0,  4'd15};
  logic [3:0] w4_d [4] = '{4'd14, 4'd0, 4'd15, 4'd1};
  logic       w4_bo[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_diff", {31'd0, d1}, 0);
    chk("rst_borrow", {31'd0, bo1}, 0);
    chk("rst_ov", {31'd0, ov1}, 0);
    chk("rst_cnt", {24'd0, c1}, 0);
    chk("rst_cnt_w4", {24'd0, c3}, 0);
    rst = 1'b0;

    // WIDTH=1 truth table, back-to-back
    v1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [4:0] v;
      v = tt_vec[i];
      a1 = v[4];
      b1 = v[3];
      tick();
      chk($sformatf("tt%0d_diff", i), {31'd0, d1}, {31'd0, v[2]});
      chk($sformatf("tt%0d_borrow", i), {31'd0, bo1}, {31'd0, v[1]});
      chk($sformatf("tt%0d_ov", i), {31'd0, ov1}, 1);
      chk($sformatf("tt%0d_cnt", i), {24'd0, c1}, {31'd0, v[0]});
    end

    // reset overrides valid input for two cycles
    rst = 1'b1;
    a1 = 1'b0;
    b1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("rv%0d_diff", i), {31'd0, d1}, 0);
      chk($sformatf("rv%0d_borrow", i), {31'd0, bo1}, 0);
      chk($sformatf("rv%0d_ov", i), {31'd0, ov1}, 0);
      chk($sformatf("rv%0d_cnt", i), {24'd0, c1}, 0);
    end
    rst = 1'b0;
    tick();
    chk("post_rst_diff", {31'd0, d1}, 1);
    chk("post_rst_borrow", {31'd0, bo1}, 1);
    chk("post_rst_ov", {31'd0, ov1}, 1);
    chk("post_rst_cnt", {24'd0, c1}, 1);

    // hold: one valid result, then three idle cycles with changed operands
    a1 = 1'b1;
    b1 = 1'b0;
    tick();
    chk("hold_load_diff", {31'd0, d1}, 1);
    chk("hold_load_borrow", {31'd0, bo1}, 0);
    v1 = 1'b0;
    a1 = 1'b0;
    b1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold%0d_diff", i), {31'd0, d1}, 1);
      chk($sformatf("hold%0d_borrow", i), {31'd0, bo1}, 0);
      chk($sformatf("hold%0d_ov", i), {31'd0, ov1}, 0);
      chk($sformatf("hold%0d_cnt", i), {24'd0, c1}, 1);
    end

    // saturation on a 2-bit counter
    v2 = 1'b1;
    a2 = 1'b0;
    b2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("sat%0d_cnt", i), {30'd0, c2}, {30'd0, sat_exp[i]});
    end
    v2 = 1'b0;

    // WIDTH=4 vectors
    v3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a3 = w4_a[i];
      b3 = w4_b[i];
      tick();
      chk($sformatf("w4_%0d_diff", i), {28'd0, d3}, {28'd0, w4_d[i]});
      chk($sformatf("w4_%0d_borrow", i), {31'd0, bo3}, {31'd0, w4_bo[i]});
      chk($sformatf("w4_%0d_ov", i), {31'd0, ov3}, 1);
    end
    chk("w4_cnt", {24'd0, c3}, 2);
    v3 = 1'b0;

    // reset in the middle of a stream
    v1 = 1'b1;
    a1 = 1'b0;
    b1 = 1'b1;
    tick();
    tick();
    chk("stream_cnt", {24'd0, c1}, 3);
    rst = 1'b1;
    tick();
    chk("mid_rst_diff", {31'd0, d1}, 0);
    chk("mid_rst_ov", {31'd0, ov1}, 0);
    chk("mid_rst_cnt", {24'd0, c1}, 0);
    rst = 1'b0;
    v1 = 1'b0;
    tick();
    chk("mid_idle_ov", {31'd0, ov1}, 0);
    chk("mid_idle_diff", {31'd0, d1}, 0);
    chk("mid_idle_borrow", {31'd0, bo1}, 0);
    v1 = 1'b1;
    a1 = 1'b1;
    b1 = 1'b1;
    tick();
    chk("mid_eq_diff", {31'd0, d1}, 0);
    chk("mid_eq_ov", {31'd0, ov1}, 1);
    chk("mid_eq_cnt", {24'd0, c1}, 0);
    a1 = 1'b0;
    tick();
    chk("mid_b_diff", {31'd0, d1}, 1);
    chk("mid_b_borrow", {31'd0, bo1}, 1);
    chk("mid_b_cnt", {24'd0, c1}, 1);
    v1 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
